// File: rtl/hs_pkg.sv
// Shared types and constants for the 10-bit high-speed serial link.
package hs_pkg;

  localparam int unsigned HS_WORD_W = 10;
  localparam logic [HS_WORD_W-1:0] HS_SYNC_DEFAULT = 10'b1111001111;

  typedef enum logic {
    HUNT,
    LOCKED
  } hs_rx_state_t;

endpackage

// File: rtl/hs_sipo_sr.sv
// 10-bit serial-in shift register, MSB first, with synchronous clear.
// Exposes both the registered value and the value it will take on the next shift.
module hs_sipo_sr
  import hs_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 shift_i,
  input  logic                 bit_i,
  output logic [HS_WORD_W-1:0] sr_o,
  output logic [HS_WORD_W-1:0] sr_next_o
);

  logic [HS_WORD_W-1:0] sr_q, sr_d;

  assign sr_next_o = {sr_q[HS_WORD_W-2:0], bit_i};

  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (shift_i) begin
      sr_d = sr_next_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr_o = sr_q;

endmodule

// File: rtl/hs_rx_deser.sv
// Receive deserialiser: hunts for a sync word, then assembles 10-bit words and
// presents them on a ready/valid holding register. n_rst is active-high.
module hs_rx_deser
  import hs_pkg::*;
#(
  parameter logic [HS_WORD_W-1:0] SYNC_WORD = HS_SYNC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 shift_enable,
  input  logic                 resync,
  input  logic                 rx_ready,
  output logic [HS_WORD_W-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 locked,
  output logic                 sync_seen,
  output logic                 overrun
);

  hs_rx_state_t         state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [HS_WORD_W-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 sync_q, sync_d;
  logic                 ovr_q, ovr_d;
  logic                 load;

  logic [HS_WORD_W-1:0] sr_q;
  logic [HS_WORD_W-1:0] sr_next;
  logic                 unused_sr;

  hs_sipo_sr u_sipo (
    .clk_i     (clk),
    .rst_i     (n_rst),
    .clr_i     (resync),
    .shift_i   (shift_enable),
    .bit_i     (serial_in),
    .sr_o      (sr_q),
    .sr_next_o (sr_next)
  );

  // Only the look-ahead value drives decisions; the registered value is not needed here.
  assign unused_sr = ^sr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sync_d  = 1'b0;
    ovr_d   = 1'b0;
    load    = 1'b0;

    if (resync) begin
      state_d = HUNT;
      cnt_d   = 4'd0;
    end else if (shift_enable) begin
      case (state_q)
        HUNT: begin
          if (sr_next == SYNC_WORD) begin
            state_d = LOCKED;
            cnt_d   = 4'd0;
            sync_d  = 1'b1;
          end
        end
        LOCKED: begin
          if (cnt_q == 4'd9) begin
            cnt_d = 4'd0;
            if (sr_next == SYNC_WORD) begin
              sync_d = 1'b1;
            end else if (valid_q && !rx_ready) begin
              ovr_d = 1'b1;
            end else begin
              load = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // A word landing on the consume edge replaces the consumed one.
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = sr_next;
      valid_d = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q <= HUNT;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign locked    = (state_q == LOCKED);
  assign sync_seen = sync_q;
  assign overrun   = ovr_q;

endmodule

// File: doc/hs_rx_deser.md
# hs_rx_deser

Receive-side counterpart of the 10-bit high-speed parallel-to-serial transmitter (`hs_sr`). It samples one serial bit per `shift_enable` strobe, MSB first, and hunts for a 10-bit sync word to find word boundaries. Once aligned, it assembles 10-bit words and presents them on a ready/valid output interface. It sits between the serial line sampler and the downstream 10-bit symbol decoder.

## Interface
- `SYNC_WORD`, default 10'b1111001111: alignment pattern; in LOCKED it is treated as idle fill and is not forwarded.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous reset, active-high despite the name (reset asserted while `n_rst`=1).
- `serial_in`  in  1  serial data bit, sampled when `shift_enable`=1.
- `shift_enable`  in  1  one-cycle strobe per received bit.
- `resync`  in  1  synchronous request to drop lock and return to HUNT.
- `rx_ready`  in  1  downstream accepts `rx_data` this cycle.
- `rx_data`  out  10  assembled word, MSB = first received bit.
- `rx_valid`  out  1  `rx_data` holds an unconsumed word.
- `locked`  out  1  high in LOCKED state.
- `sync_seen`  out  1  one-cycle pulse when a sync word is recognised, in either state.
- `overrun`  out  1  one-cycle pulse when a completed word is dropped because the holding register is full.

## Operation
- Reset values: shift register 0, bit counter 0, state HUNT, `rx_data`=0, `rx_valid`=0, `locked`=0, `sync_seen`=0, `overrun`=0.
- Shift update: on `shift_enable`, sr_next = {sr[8:0], serial_in}, so the first received bit ends at bit 9.
- States: HUNT, LOCKED.
- HUNT:
  - On each shift, compare sr_next to `SYNC_WORD`.
  - On a match: go to LOCKED, clear the bit counter, pulse `sync_seen`.
  - Nothing is forwarded in HUNT.
- LOCKED:
  - The bit counter counts 0..9 on each shift and wraps to 0 after 9.
  - On the shift where the counter equals 9, the word is sr_next and is handled as follows:
    - If the word equals `SYNC_WORD`: drop it and pulse `sync_seen`.
    - Else if `rx_valid`=1 and `rx_ready`=0: drop the new word, keep the old `rx_data`, pulse `overrun`.
    - Else: load `rx_data` with the word and set `rx_valid`=1.
- Output handshake:
  - `rx_valid` clears on the edge where `rx_valid`&&`rx_ready` and no new word loads.
  - If a word completes on the same edge as a consume, the new word loads, `rx_valid` stays 1, and no overrun occurs.
  - `rx_data` is stable while `rx_valid`=1 and not consumed.
- `resync`:
  - Has priority over `shift_enable`.
  - Next state is HUNT, bit counter and shift register clear, `locked`=0.
  - `rx_data` and `rx_valid` are unaffected, so a pending word can still be consumed.
- Reset mid-word discards partial bits and any pending word.
- `shift_enable`=0: no state change except the output handshake.

## Timing
- Latency: `rx_valid` and `rx_data` are registered on the edge that samples the 10th bit, so they are visible in the following cycle.
- `locked` rises in the cycle after the edge that samples the final sync bit.
- `sync_seen` and `overrun` are registered pulses exactly one clock wide, coincident with the state and data update.
- Back-to-back strobes (`shift_enable` high every cycle) are supported. The minimum word period is 10 clocks, so a word is presented at most every 10 cycles.
- Shift-to-shift spacing is arbitrary; the bit counter advances only on strobes.

## Structure
- Package `hs_pkg` holds:
  - `HS_WORD_W` = 10.
  - `HS_SYNC_DEFAULT` = 10'b1111001111.
  - `hs_rx_state_t` enum {HUNT, LOCKED}.
- Sub-module `hs_sipo_sr`: 10-bit serial-in shift register with synchronous clear. It provides both the registered value and sr_next.
- The top level holds:
  - the FSM;
  - the 4-bit bit counter;
  - the compare logic;
  - the output holding register and handshake.

## Test plan
- Alignment:
  - Stimulus: reset, then shift 3 junk bits followed by 1111001111 MSB first.
  - Required: `sync_seen` pulse, `locked`=1 the next cycle, `rx_valid` stays 0.
- Word receive:
  - Stimulus: while locked, shift 0001111100 with `rx_ready`=1.
  - Required: `rx_valid`=1 with `rx_data`=10'b0001111100 the cycle after the 10th strobe, cleared on the next edge.
- Idle fill:
  - Stimulus: while locked, shift `SYNC_WORD`.
  - Required: `sync_seen` pulse, no `rx_valid`, counter realigned at 0.
- Overrun:
  - Stimulus: hold `rx_ready`=0 and receive words 0000000001 then 0000000010.
  - Required: `overrun` pulse, `rx_data` stays 0000000001, `rx_valid`=1.
- Simultaneous consume and complete:
  - Stimulus: `rx_ready`=1 on the same edge as the 10th bit of 1010101010.
  - Required: `rx_data`=1010101010, `rx_valid` stays 1, no `overrun`.
- Resync and reset:
  - Stimulus 1: assert `resync` mid-word. Required: `locked`=0 the next cycle and a partial word never appears.
  - Stimulus 2: assert `n_rst` mid-word. Required: all outputs return to 0 immediately (asynchronous).
